alu_muldiv: RTL and testbench

- Next-generation datapath ALU for the MIPS core, parametrised in WIDTH.
- Keeps the single-cycle logic/arith ops: AND, OR, ADD, SUB, SLT, NOR.
- Adds signed overflow detection and an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
- Sits in EX stage; control stalls the pipeline while busy=1.

---
 rtl/alu_muldiv.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
`timescale 1ns/1ps
// alu_muldiv: EX-stage datapath ALU with an iterative multiply/divide unit.
//   Single-cycle ops (AND, OR, ADD, SUB, SLT, NOR, MFHI, MFLO) drive result,
//   zero and overflow combinationally. MULTU/DIVU (and MULT/DIV when the
//   ALU_SIGNED_MULDIV_EN macro is defined) run one bit per cycle on a shared
//   2*WIDTH accumulator and update hi/lo on entry to FIN.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   A, B              operands (dividend/multiplicand, divisor/multiplier)
//   ALUOp             operation select
//   start             launch a mul/div op (ignored while busy or for other codes)
//   result, zero      combinational result and result==0 flag
//   overflow          signed overflow for ADD/SUB
//   hi, lo            HI/LO registers (product halves or remainder/quotient)
//   busy              iterative op in progress
//   done              one-cycle pulse when hi/lo have been written
// Configuration macro: ALU_SIGNED_MULDIV_EN enables signed MULT (1001) and DIV (1011).
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1011;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;      // mul: {partial, multiplier}; div: {remainder, dividend}
  logic [WIDTH-1:0]     opd;      // multiplicand or divisor magnitude
  logic                 neg_q;    // negate product / quotient at FIN
  logic                 neg_r;    // negate remainder at FIN

  // Single-cycle ALU
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;

  assign sum  = A + B;
  assign diff = A - B;
  assign slt  = $signed(A) < $signed(B);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ALUOp)
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_ADD: begin
        result   = sum;
        overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      OP_SLT:  result = WIDTH'(slt);
      OP_NOR:  result = ~(A | B);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Mul/div op decode
  logic is_mul;
  logic is_div;
  logic is_signed;

`ifdef ALU_SIGNED_MULDIV_EN
  assign is_mul    = (ALUOp == OP_MULTU) || (ALUOp == OP_MULT);
  assign is_div    = (ALUOp == OP_DIVU)  || (ALUOp == OP_DIV);
  assign is_signed = (ALUOp == OP_MULT)  || (ALUOp == OP_DIV);
`else
  assign is_mul    = (ALUOp == OP_MULTU);
  assign is_div    = (ALUOp == OP_DIVU);
  assign is_signed = 1'b0;
`endif

  // Operand magnitudes; the most-negative value maps onto its own unsigned magnitude
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = is_signed & A[MSB];
  assign b_neg = is_signed & B[MSB];
  assign a_mag = a_neg ? (-A) : A;
  assign b_mag = b_neg ? (-B) : B;

  // One shift-add multiply step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step; trial's top bit set means the subtraction underflowed
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, opd};
  assign div_next  = div_trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up applied on the final iteration
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q ? (-mul_next) : mul_next;
  assign quo_fix  = neg_q ? (-div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
  assign rem_fix  = neg_r ? (-div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];

  logic last_iter;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Mul/div sequencer with registered busy/done/hi/lo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opd   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (start && is_mul) begin
            state <= ST_MUL;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= {WIDTH'(0), b_mag};
            opd   <= a_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= 1'b0;
          end else if (start && is_div) begin
            if (B == '0) begin
              // Divide-by-zero completes immediately with fixed results
              state <= ST_FIN;
              done  <= 1'b1;
              hi    <= A;
              lo    <= '1;
            end else begin
              state <= ST_DIV;
              busy  <= 1'b1;
              cnt   <= '0;
              acc   <= {WIDTH'(0), a_mag};
              opd   <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        ST_MUL: begin
          cnt <= cnt + CNT_W'(1);
          acc <= mul_next;
          if (last_iter) begin
            state    <= ST_FIN;
            busy     <= 1'b0;
            done     <= 1'b1;
            {hi, lo} <= prod_fix;
          end
        end
        ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          acc <= div_next;
          if (last_iter) begin
            state <= ST_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= rem_fix;
            lo    <= quo_fix;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
// Self-checking bench for alu_muldiv (WIDTH=32): combinational vector table,
// randomized ALU ops against an arithmetic model, and multi-cycle mul/div
// sequences (latency, busy/done, back-to-back, start-while-busy, reset abort).
module tb_alu_muldiv;
  localparam int unsigned W = 32;
  localparam logic [3:0] MULTU = 4'b1000;
  localparam logic [3:0] DIVU  = 4'b1010;
  localparam logic [3:0] MULT  = 4'b1001;
  localparam logic [3:0] DIV   = 4'b1011;
  localparam logic [3:0] MFHI  = 4'b1101;
  localparam logic [3:0] MFLO  = 4'b1110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic [3:0]   ALUOp;
  logic         start;
  logic [W-1:0] result, hi, lo;
  logic         zero, overflow, busy, done;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUOp(ALUOp), .start(start),
    .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU reference: true-integer arithmetic, overflow when the wrapped result differs
  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic ov);
    longint s;
    r  = '0;
    ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s  = longint'($signed(a)) + longint'($signed(b));
        r  = W'(s);
        ov = (s != longint'($signed(r)));
      end
      4'b0110: begin
        s  = longint'($signed(a)) - longint'($signed(b));
        r  = W'(s);
        ov = (s != longint'($signed(r)));
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: r = ~(a | b);
      4'b1101: r = m_hi;
      4'b1110: r = m_lo;
      default: r = '0;
    endcase
  endfunction

  // Mul/div reference using 64-bit integer arithmetic
  function automatic void ref_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] ehi, output logic [W-1:0] elo, output int lat);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = W + 1;
    ehi = '0;
    elo = '0;
    if ((op == DIVU || op == DIV) && b == '0) begin
      ehi = a;
      elo = '1;
      lat = 1;
    end else if (op == MULTU) begin
      p   = 64'(a) * 64'(b);
      ehi = p[63:32];
      elo = p[31:0];
    end else if (op == MULT) begin
      q   = sa * sb;
      ehi = W'(q >>> 32);
      elo = W'(q);
    end else if (op == DIVU) begin
      ehi = a % b;
      elo = a / b;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      ehi = W'(r);
      elo = W'(q);
    end
  endfunction

  // Launch an op at the current negedge and follow it to done; optionally hammer start while busy
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat,
                       input bit noisy, input string name);
    logic hs_ok;
    hs_ok = 1'b1;
    ALUOp = op; A = a; B = b; start = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (busy !== (k < lat) || done !== (k == lat)) hs_ok = 1'b0;
      if (k < lat && (hi !== m_hi || lo !== m_lo)) hs_ok = 1'b0;
      A = $urandom;
      B = $urandom;
      start = noisy && (k < lat);
    end
    chk({name, " handshake"}, 64'(hs_ok), 64'(1));
    chk({name, " hi"}, 64'(hi), 64'(ehi));
    chk({name, " lo"}, 64'(lo), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
    ALUOp = MFLO;
    #1 chk({name, " mflo"}, 64'(result), 64'(elo));
    ALUOp = MFHI;
    #1 chk({name, " mfhi"}, 64'(result), 64'(ehi));
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    chk({name, " done pulse end"}, {62'(0), busy, done}, 64'(0));
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    logic         z, ov;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, rr, ehi, elo;
    logic [3:0]   rop;
    logic         rov, seen;
    int           lat;

    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[4]  = '{4'b0011, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[8]  = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{4'b1000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
    vecs[12] = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};

    ALUOp = 4'b0000; A = '0; B = '0; start = 1'b0; rst_n = 1'b0;
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    ALUOp = MFHI;
    #1 chk("reset mfhi", {31'(0), result, zero}, {31'(0), 32'h0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational vector table
    for (int i = 0; i < 13; i++) begin
      ALUOp = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
      #1 chk($sformatf("vec%0d", i), {30'(0), result, zero, overflow},
             {30'(0), vecs[i].r, vecs[i].z, vecs[i].ov});
    end

    // Random combinational ops against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = (i % 10 == 0) ? 32'h7FFF_FFFF : $urandom;
      rb  = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      ref_alu(rop, ra, rb, rr, rov);
      ALUOp = rop; A = ra; B = rb;
      #1 chk($sformatf("rand alu op=%0h a=%0h b=%0h", rop, ra, rb),
             {30'(0), result, zero, overflow}, {30'(0), rr, (rr == '0), rov});
    end

    // Directed multi-cycle cases
    @(negedge clk);
    do_op(MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 33, 1'b0, "multu");
    check_quiet("multu");
    do_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1, "divu busy-start");
    check_quiet("divu");
    do_op(DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 1'b0, "divu by zero");
    check_quiet("divu0");

    // Back-to-back: next start accepted in FIN
    do_op(MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 33, 1'b0, "b2b mul");
    do_op(DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 33, 1'b0, "b2b div");
    do_op(DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1, 1'b0, "b2b div0");
    check_quiet("b2b");

    // start with a non-mul/div code must not launch anything
    ALUOp = 4'b0010; A = 32'd3; B = 32'd4; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("start ignored add", {30'(0), busy, done, (hi == m_hi && lo == m_lo)}, 64'(1));
`ifndef ALU_SIGNED_MULDIV_EN
    ALUOp = MULT;
    #1 chk("mult code result", {31'(0), result, zero}, {31'(0), 32'h0, 1'b1});
    @(negedge clk);
    ALUOp = DIV; B = 32'd2;
    @(negedge clk);
    @(negedge clk);
    chk("signed codes ignored", {30'(0), busy, done, (hi == m_hi && lo == m_lo)}, 64'(1));
`endif
    start = 1'b0;
    @(negedge clk);

    // Random unsigned mul/div
    for (int i = 0; i < 16; i++) begin
      rop = (i % 2 == 0) ? MULTU : DIVU;
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      ref_md(rop, ra, rb, ehi, elo, lat);
      do_op(rop, ra, rb, ehi, elo, lat, ($urandom_range(0, 1) == 1),
            $sformatf("rand md op=%0h a=%0h b=%0h", rop, ra, rb));
    end
    check_quiet("rand md");

    // Asynchronous reset in the middle of a MULTU
    ALUOp = MULTU; A = 32'h1234_5678; B = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort hilo", {hi, lo}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("no done after abort", 64'(seen), 64'(0));

`ifdef ALU_SIGNED_MULDIV_EN
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0, "div -7/2");
    do_op(MULT, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 33, 1'b0, "mult -3*4");
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0, "div min/-1");
    do_op(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 1'b0, "div signed by zero");
    for (int i = 0; i < 10; i++) begin
      rop = (i % 2 == 0) ? MULT : DIV;
      ra  = $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? -32'($urandom_range(1, 9)) : $urandom;
      ref_md(rop, ra, rb, ehi, elo, lat);
      do_op(rop, ra, rb, ehi, elo, lat, 1'b0, $sformatf("rand signed op=%0h a=%0h b=%0h", rop, ra, rb));
    end
    check_quiet("signed");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
